uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6: width of Prescale.
REQ-003 SHALL have port CLK  in  1  single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_IN  in  1  serial line; idles high.
REQ-006 SHALL have port Prescale  in  PRESCALE_W  CLK cycles per bit; legal values are 4..2^PRESCALE_W-1.
REQ-007 SHALL have port PAR_EN  in  1  parity bit present when 1.
REQ-008 SHALL have port PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port P_DATA  out  DATA_WIDTH  received word.
REQ-010 SHALL have port Data_Valid  out  1  one-cycle pulse; P_DATA is valid in that cycle.
REQ-011 SHALL have port Par_Err  out  1  one-cycle pulse on a parity mismatch.
REQ-012 SHALL have port Stp_Err  out  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-013 SHALL pass RX_IN through a 2-flop synchronizer reset to 1; all timing below refers to the synchronized signal rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, in IDLE with armed=1 and rx_s=0, go to START; this detection cycle is edge 0.
REQ-016 SHALL capture Prescale, PAR_EN and PAR_TYP on the detection cycle and hold them for the whole frame.
REQ-017 SHALL keep edge_cnt in the range 0..Prescale-1 within each bit, and increment bit_cnt when edge_cnt wraps.
REQ-018 SHALL decide each bit by 2-of-3 majority vote of rx_s samples at edge_cnt = P/2-1, P/2 and P/2+1 (P = captured Prescale, integer divide).
REQ-019 SHALL return to IDLE from START with no output pulse if the voted start bit is 1 (glitch rejection).
REQ-020 SHALL shift DATA bits LSB first; DATA lasts DATA_WIDTH bit periods and then goes to PARITY if PAR_EN else STOP.
REQ-021 SHALL, in PARITY, compare the voted bit with the XOR of the data bits (inverted for odd parity); on mismatch it SHALL latch a pending parity error.
REQ-022 SHALL, at the last edge of STOP, pulse exactly one of Stp_Err (stop bit=0), else Par_Err (pending parity error), else Data_Valid; then go to IDLE.
REQ-023 SHALL update P_DATA only together with a Data_Valid pulse and hold it otherwise; an errored frame SHALL NOT change P_DATA.
REQ-024 SHALL time the Data_Valid pulse at cycle N*P-1 after detection, where N = DATA_WIDTH+2+PAR_EN.
REQ-025 SHALL allow back-to-back frames: a start edge on the first cycle in IDLE is accepted, with no dead cycle beyond the return to IDLE.
REQ-026 SHALL clear armed after a Stp_Err and set it again only once rx_s=1 is seen, so a held-low line (break) yields exactly one Stp_Err.
REQ-027 SHALL never assert two output pulses in the same cycle.

Reset
REQ-028 SHALL, while RST=0, force the FSM to IDLE, clear P_DATA, Data_Valid, Par_Err, Stp_Err, edge_cnt, bit_cnt and the pending parity error, set armed=1, and set the synchronizer flops to 1.
REQ-029 SHALL discard any frame in flight when reset is asserted, with no pulse after release; reception SHALL resume with the next start edge.

Structure
REQ-030 SHALL place the state encoding and the PAR_EVEN/PAR_ODD constants in shared package uart_pkg, which is also used by the transmitter.
REQ-031 SHALL implement sampling and majority vote in sub-module uart_rx_sampler (inputs: rx_s, edge_cnt, P; output: voted bit); the FSM, counters and deserializer live in uart_rx.

Verification
REQ-032 SHALL cover: Prescale=8, PAR_EN=0, byte 0xA5 -> Data_Valid one cycle at cycle 79, P_DATA=0xA5.
REQ-033 SHALL cover: Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 0 -> Data_Valid at cycle 175, P_DATA=0x3C; the same frame with parity bit 1 -> Par_Err pulse, P_DATA unchanged.
REQ-034 SHALL cover: Prescale=8, a 2-cycle low glitch on RX_IN -> no output pulses, FSM back in IDLE by cycle 8.
REQ-035 SHALL cover: Prescale=8, a frame with stop bit 0 followed by a line held low for 200 cycles -> exactly one Stp_Err; frame 0x55 sent after the line returns high -> Data_Valid with P_DATA=0x55.
REQ-036 SHALL cover: two back-to-back frames 0x01 and 0xFE at Prescale=32 -> two Data_Valid pulses exactly 320 cycles apart.
REQ-037 SHALL cover: RST asserted at the 4th data bit of a frame -> all outputs 0, P_DATA=0; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and parity-type constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Frame phases, shared with the transmitter so both sides decode the same encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // PAR_TYP encodings.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit 2-of-3 majority voter: samples rx_s at P/2-1, P/2 and P/2+1 within each bit period.
// Latency: voted is valid from edge P/2+1 (combinational on the third sample) until the bit ends.
// Backpressure: none; it follows the bit timing set by edge_cnt.
//
// Ports:
//   CLK, RST  - clock and asynchronous active-low reset
//   rx_s      - synchronized serial line
//   edge_cnt  - position within the current bit, 0..P-1
//   P         - captured prescale (clock cycles per bit)
//   voted     - majority value of the three mid-bit samples
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] P,
  output logic                  voted
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] mid_idx;
  logic [PRESCALE_W-1:0] lo_idx;
  logic [PRESCALE_W-1:0] hi_idx;
  logic                  s_lo;
  logic                  s_mid;
  logic                  s_hi;
  logic                  third;

  assign mid_idx = P >> 1;
  assign lo_idx  = mid_idx - ONE;
  assign hi_idx  = mid_idx + ONE;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
      s_hi  <= 1'b1;
    end else begin
      if (edge_cnt == lo_idx)  s_lo  <= rx_s;
      if (edge_cnt == mid_idx) s_mid <= rx_s;
      if (edge_cnt == hi_idx)  s_hi  <= rx_s;
    end
  end

  // At P=4 the third sample lands on the last edge of the bit, where the FSM
  // already needs the decision, so the live line value is used on that edge.
  assign third = (edge_cnt == hi_idx) ? rx_s : s_hi;
  assign voted = (s_lo & s_mid) | (s_lo & third) | (s_mid & third);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, majority-voted bits, LSB-first deserializer, optional parity, stop check.
// Latency: result pulse N*P-1 cycles after the start-edge detection cycle (N = DATA_WIDTH+2+PAR_EN).
// Backpressure: none; every pulse lasts one cycle and P_DATA holds until the next good frame.
//
// Ports:
//   CLK, RST           - clock and asynchronous active-low reset
//   RX_IN              - asynchronous serial line, idles high
//   Prescale           - clock cycles per bit (4..2^PRESCALE_W-1)
//   PAR_EN, PAR_TYP    - parity present / odd parity
//   P_DATA, Data_Valid - received word and its one-cycle strobe
//   Par_Err, Stp_Err   - one-cycle error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int                    BC_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BC_W-1:0]       BC_LAST = BC_W'(DATA_WIDTH - 1);
  localparam logic [BC_W-1:0]       BC_ONE  = BC_W'(1);
  localparam logic [PRESCALE_W-1:0] EC_ONE  = PRESCALE_W'(1);

  uart_state_t state;
  uart_state_t nxt_state;

  logic                  rx_meta;
  logic                  rx_s;
  logic                  armed;
  logic [PRESCALE_W-1:0] p_cap;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_pend;
  logic                  voted;
  logic                  wrap;
  logic                  par_exp;

  logic start_frame;
  logic shift_en;
  logic par_chk;
  logic dv_set;
  logic pe_set;
  logic se_set;

  // Two-flop synchronizer; reset high so a reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .rx_s     (rx_s),
    .edge_cnt (edge_cnt),
    .P        (p_cap),
    .voted    (voted)
  );

  assign wrap    = (edge_cnt == (p_cap - EC_ONE));
  assign par_exp = (^shreg) ^ (par_typ_q == PAR_ODD);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nxt_state;
  end

  always_comb begin
    nxt_state   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    dv_set      = 1'b0;
    pe_set      = 1'b0;
    se_set      = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          nxt_state   = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (wrap) nxt_state = voted ? IDLE : DATA;
      end
      DATA: begin
        if (wrap) begin
          shift_en = 1'b1;
          if (bit_cnt == BC_LAST) nxt_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (wrap) begin
          par_chk   = 1'b1;
          nxt_state = STOP;
        end
      end
      STOP: begin
        if (wrap) begin
          nxt_state = IDLE;
          // Framing error outranks parity error; only a clean frame delivers data.
          if (!voted)        se_set = 1'b1;
          else if (par_pend) pe_set = 1'b1;
          else               dv_set = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Counters, frame settings and deserializer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_cap     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_pend  <= 1'b0;
    end else begin
      if (start_frame) begin
        // The detection cycle is edge 0 of the start bit, so counting resumes at 1.
        p_cap     <= Prescale;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        edge_cnt  <= EC_ONE;
        bit_cnt   <= '0;
        par_pend  <= 1'b0;
      end else if (state != IDLE) begin
        edge_cnt <= wrap ? '0 : edge_cnt + EC_ONE;
      end
      if (shift_en) begin
        shreg   <= {voted, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= (bit_cnt == BC_LAST) ? '0 : bit_cnt + BC_ONE;
      end
      if (par_chk && (voted != par_exp)) par_pend <= 1'b1;
      if (dv_set || pe_set || se_set)    par_pend <= 1'b0;
    end
  end

  // Registered result strobes and held output word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= dv_set;
      Par_Err    <= pe_set;
      Stp_Err    <= se_set;
      if (dv_set) P_DATA <= shreg;
    end
  end

  // After a framing error the line must be seen high before the next start
  // is accepted, so a held-low break reports a single Stp_Err.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed <= 1'b1;
    end else if (se_set) begin
      armed <= 1'b0;
    end else if ((state == IDLE) && rx_s) begin
      armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames plus glitch, break, back-to-back and reset sequences.
// Latency: results sampled on the falling edge, a fixed number of cycles after each frame ends.
// Backpressure: n/a (bench drives the serial line bit-by-bit).
module tb_uart_rx;
  import uart_pkg::*;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  uart_rx #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Number of rising edges so far; stable when read on a falling edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor.
  int         dv_n = 0, pe_n = 0, se_n = 0, multi_n = 0;
  int         pulse_cyc = 0, dv_cyc = 0, dv_prev_cyc = 0;
  logic [7:0] dv_dat = 8'h00, dv_prev_dat = 8'h00;
  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_n++;
      dv_prev_cyc = dv_cyc;
      dv_cyc      = cyc;
      dv_prev_dat = dv_dat;
      dv_dat      = P_DATA;
      pulse_cyc   = cyc;
    end
    if (Par_Err) begin
      pe_n++;
      pulse_cyc = cyc;
    end
    if (Stp_Err) begin
      se_n++;
      pulse_cyc = cyc;
    end
    if (int'(Data_Valid) + int'(Par_Err) + int'(Stp_Err) > 1) multi_n++;
  end

  int pass_n = 0, total_n = 0;
  int drv_cyc = 0;
  int s_dv = 0, s_pe = 0, s_se = 0;

  // Rising edges from driving the start bit to the detection cycle: two sync flops plus the detect edge.
  localparam int SYNC_LAT = 3;

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic snap();
    s_dv = dv_n;
    s_pe = pe_n;
    s_se = se_n;
  endtask

  task automatic align();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // Caller must be 1 time unit after a rising edge; returns in the same phase.
  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit pbit, input bit sbit, input int hold_low);
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    drv_cyc  = cyc;
    RX_IN    = 1'b0;
    repeat (p) @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(posedge CLK);
      #1;
    end
    if (pen) begin
      RX_IN = pbit;
      repeat (p) @(posedge CLK);
      #1;
    end
    RX_IN = sbit;
    repeat (p) @(posedge CLK);
    #1;
    if (hold_low > 0) begin
      RX_IN = 1'b0;
      repeat (hold_low) @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
  endtask

  task automatic check_frame(input string name, input int e_dv, input int e_pe, input int e_se,
                             input logic [7:0] e_pd, input int e_lat);
    repeat (12) @(posedge CLK);
    #1;
    chk({name, "_dv"},    dv_n - s_dv, e_dv);
    chk({name, "_pe"},    pe_n - s_pe, e_pe);
    chk({name, "_se"},    se_n - s_se, e_se);
    chk({name, "_lat"},   pulse_cyc - (drv_cyc + SYNC_LAT), e_lat);
    chk({name, "_pdata"}, int'(P_DATA), int'(e_pd));
  endtask

  typedef struct {
    int         presc;
    bit         par_en;
    bit         par_typ;
    logic [7:0] data;
    bit         par_bit;
    bit         stop_bit;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int det;
    //          P   pen ptyp data   pbit stop dv pe se pdata  lat
    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5, 79};
    vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C, 175};
    vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'h3C, 175};
    vecs[3] = '{16, 1'b1, 1'b1, 8'h3D, 1'b0, 1'b1, 1, 0, 0, 8'h3D, 175};
    vecs[4] = '{4,  1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1, 0, 0, 8'h96, 39};
    vecs[5] = '{63, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A, 629};
    vecs[6] = '{8,  1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 0, 0, 1, 8'h5A, 79};
    vecs[7] = '{5,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 0, 1, 0, 8'h5A, 54};
    vecs[8] = '{8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 0, 0, 1, 8'h5A, 87};
    vecs[9] = '{8,  1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C, 87};

    RST      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pdata", int'(P_DATA), 0);
    chk("rst_dv",    int'(Data_Valid), 0);
    chk("rst_pe",    int'(Par_Err), 0);
    chk("rst_se",    int'(Stp_Err), 0);
    chk("rst_state", int'(dut.state), int'(IDLE));
    align();
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;

    // Directed frames.
    for (int v = 0; v < 10; v++) begin
      snap();
      send_frame(vecs[v].presc, vecs[v].par_en, vecs[v].par_typ, vecs[v].data,
                 vecs[v].par_bit, vecs[v].stop_bit, 0);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_dv, vecs[v].exp_pe, vecs[v].exp_se,
                  vecs[v].exp_pdata, vecs[v].exp_lat);
    end

    // Two-cycle low glitch at P=8: start is detected, then rejected.
    snap();
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    drv_cyc  = cyc;
    RX_IN    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    det = drv_cyc + SYNC_LAT;
    wait_cyc(det + 1);
    chk("glitch_start", int'(dut.state), int'(START));
    wait_cyc(det + 8);
    chk("glitch_idle", int'(dut.state), int'(IDLE));
    align();
    repeat (20) @(posedge CLK);
    #1;
    chk("glitch_pulses", (dv_n - s_dv) + (pe_n - s_pe) + (se_n - s_se), 0);

    // Stop bit low followed by a 200-cycle break, then a good frame.
    snap();
    send_frame(8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 200);
    repeat (20) @(posedge CLK);
    #1;
    chk("brk_se", se_n - s_se, 1);
    chk("brk_dv", dv_n - s_dv, 0);
    chk("brk_pe", pe_n - s_pe, 0);
    snap();
    send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0);
    check_frame("brk_next", 1, 0, 0, 8'h55, 79);

    // Back-to-back frames at P=32.
    snap();
    send_frame(32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 0);
    send_frame(32, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 0);
    check_frame("b2b", 2, 0, 0, 8'hFE, 319);
    chk("b2b_gap",   dv_cyc - dv_prev_cyc, 320);
    chk("b2b_first", int'(dv_prev_dat), 8'h01);

    // Reset during the 4th data bit of 0xC3.
    snap();
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    RX_IN = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    RX_IN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_mid_state", int'(dut.state), int'(DATA));
    RST   = 1'b0;
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_pdata", int'(P_DATA), 0);
    chk("rst_mid_outs",  int'(Data_Valid) + int'(Par_Err) + int'(Stp_Err), 0);
    chk("rst_mid_idle",  int'(dut.state), int'(IDLE));
    align();
    RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    chk("rst_no_pulse", (dv_n - s_dv) + (pe_n - s_pe) + (se_n - s_se), 0);
    snap();
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 0);
    check_frame("rst_next", 1, 0, 0, 8'h81, 79);

    chk("single_pulse", multi_n, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
